// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // master: the arbiter itself
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_byte, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // slave: requesters and memory around the arbiter
    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_byte, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and data requesters; optional MEM_ARB_ANTISTARVE_EN
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus,
    output logic                busy,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              perr_q, perr_d;
    logic              if_pend_q, if_pend_d;
    logic              d_pend_q, d_pend_d;

    logic              arb_idle;
    logic              grant_d;
    logic              grant_if;
    logic              starve_hit;

    // Grants are combinational so the winner sees gnt in the same cycle it is chosen;
    // gating with rst_n keeps them low while reset is asserted.
    assign arb_idle = (state_q == S_IDLE) && rst_n;
    assign grant_d  = arb_idle && bus.d_req && !(bus.if_req && starve_hit);
    assign grant_if = arb_idle && bus.if_req && !grant_d;

`ifdef MEM_ARB_ANTISTARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q >= CW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_d && bus.if_req && (starve_q < CW'(STARVE_MAX))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // strict data priority: fetch is never forced ahead
    assign starve_hit = (STARVE_MAX < 0);
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        perr_d      = perr_q;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    owner_d = 1'b1;
                    we_d    = bus.d_we;
                    byte_d  = bus.d_byte;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = S_REQ;
                end else if (grant_if) begin
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    byte_d  = 1'b0;
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    if (we_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.mem_rvalid) begin
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = bus.mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Violations only raise the sticky flag; the FSM ignores the offending event.
        if (bus.mem_rvalid && (state_q != S_RESP)) begin
            perr_d = 1'b1;
        end
        if (bus.mem_gnt && (state_q != S_REQ)) begin
            perr_d = 1'b1;
        end
        if ((if_pend_q && !bus.if_req) || (d_pend_q && !bus.d_req)) begin
            perr_d = 1'b1;
        end
    end

    // A requester is pending from the cycle it asks without winning until it is granted.
    assign if_pend_d = bus.if_req && !grant_if;
    assign d_pend_d  = bus.d_req && !grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            perr_q      <= 1'b0;
            if_pend_q   <= 1'b0;
            d_pend_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            perr_q      <= perr_d;
            if_pend_q   <= if_pend_d;
            d_pend_q    <= d_pend_d;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;

    // The memory side is driven from registers only, so it cannot glitch while waiting for mem_gnt.
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_byte  = byte_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign busy      = (state_q != S_IDLE);
    assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .proto_err (proto_err)
    );

    int total = 0;
    int bad   = 0;

    // reference model: pending requests, starvation count, expected response pulses
    bit          i_pend, d_pend;
    logic [31:0] i_addr, d_addr_m, d_wdata_m;
    bit          d_we_m, d_byte_m;
    int          starve;
    bit          exp_iv, exp_dv, exp_perr;
    logic [31:0] exp_ird, exp_drd;
    string       order;
    string       exp_order;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    task automatic check_rv(input string tag);
        chk({tag, "_if_rvalid"}, bus.if_rvalid, exp_iv);
        chk({tag, "_if_rdata"}, bus.if_rdata, exp_ird);
        chk({tag, "_d_rvalid"}, bus.d_rvalid, exp_dv);
        chk({tag, "_d_rdata"}, bus.d_rdata, exp_drd);
        chk({tag, "_proto_err"}, proto_err, exp_perr);
        exp_iv = 0;
        exp_dv = 0;
    endtask

    task automatic clear_inputs();
        bus.if_req     = 0;
        bus.if_addr    = '0;
        bus.d_req      = 0;
        bus.d_we       = 0;
        bus.d_byte     = 0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_gnt    = 0;
        bus.mem_rvalid = 0;
        bus.mem_rdata  = '0;
    endtask

    task automatic model_reset();
        i_pend = 0; d_pend = 0; starve = 0;
        exp_iv = 0; exp_dv = 0; exp_perr = 0;
        exp_ird = '0; exp_drd = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic new_fetch(input logic [31:0] a);
        i_pend = 1; i_addr = a;
    endtask

    task automatic new_data(input bit we, input bit by, input logic [31:0] a, input logic [31:0] wd);
        d_pend = 1; d_we_m = we; d_byte_m = by; d_addr_m = a; d_wdata_m = wd;
    endtask

    task automatic new_data_rand();
        new_data(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom());
    endtask

    // Runs one arbitration plus the winner's memory transaction; starts and ends at #1 after posedge.
    task automatic round(input int gdly, input int rdly, input logic [31:0] rd);
        bit          win_d, t_we, t_byte;
        logic [31:0] t_addr, t_wdata;
        bus.if_req  = i_pend;
        bus.if_addr = i_addr;
        bus.d_req   = d_pend;
        bus.d_we    = d_we_m;
        bus.d_byte  = d_byte_m;
        bus.d_addr  = d_addr_m;
        bus.d_wdata = d_wdata_m;
        win_d = d_pend;
`ifdef MEM_ARB_ANTISTARVE_EN
        if (i_pend && d_pend && starve >= SMAX) win_d = 0;
        if (!win_d) starve = 0;
        else if (i_pend && starve < SMAX) starve++;
`endif
        @(negedge clk);
        check_rv("arb");
        chk("if_gnt", bus.if_gnt, !win_d);
        chk("d_gnt", bus.d_gnt, win_d);
        chk("busy_idle", busy, 0);
        order = {order, win_d ? "D" : "I"};
        if (win_d) begin
            t_we = d_we_m; t_byte = d_byte_m; t_addr = d_addr_m; t_wdata = d_wdata_m; d_pend = 0;
        end else begin
            t_we = 0; t_byte = 0; t_addr = i_addr; t_wdata = '0; i_pend = 0;
        end
        @(posedge clk); #1;
        if (win_d) bus.d_req = 0; else bus.if_req = 0;
        for (int k = 0; k <= gdly; k++) begin
            bus.mem_gnt = (k == gdly);
            @(negedge clk);
            chk("mem_req", bus.mem_req, 1);
            chk("mem_addr", bus.mem_addr, t_addr);
            chk("mem_we", bus.mem_we, t_we);
            chk("mem_byte", bus.mem_byte, t_byte);
            if (t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
            chk("req_gnts", {bus.if_gnt, bus.d_gnt}, 0);
            chk("req_rvalids", {bus.if_rvalid, bus.d_rvalid}, 0);
            chk("req_busy", busy, 1);
            @(posedge clk); #1;
        end
        bus.mem_gnt = 0;
        if (t_we) begin
            exp_dv = 1; exp_drd = '0;
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                bus.mem_rvalid = (k == rdly);
                bus.mem_rdata  = (k == rdly) ? rd : $urandom();
                @(negedge clk);
                chk("resp_mem_req", bus.mem_req, 0);
                chk("resp_busy", busy, 1);
                chk("resp_gnts", {bus.if_gnt, bus.d_gnt}, 0);
                chk("resp_rvalids", {bus.if_rvalid, bus.d_rvalid}, 0);
                @(posedge clk); #1;
            end
            bus.mem_rvalid = 0;
            if (win_d) begin exp_dv = 1; exp_drd = rd; end
            else       begin exp_iv = 1; exp_ird = rd; end
        end
    endtask

    task automatic idle_cycle();
        bus.if_req = 0;
        bus.d_req  = 0;
        @(negedge clk);
        check_rv("idle");
        chk("idle_gnts", {bus.if_gnt, bus.d_gnt}, 0);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        order = "";
        model_reset();
        clear_inputs();
        rst_n = 0;
        bus.if_req = 1; bus.d_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1;
        #8;
        chk("rst_gnts", {bus.if_gnt, bus.d_gnt}, 0);
        chk("rst_rvalids", {bus.if_rvalid, bus.d_rvalid}, 0);
        chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        chk("rst_mem_ctl", {bus.mem_req, bus.mem_we, bus.mem_byte}, 0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_status", {busy, proto_err}, 0);
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1;

        // zero-wait fetch, data read, then delayed byte write
        new_fetch(32'h0040_0000);
        round(0, 0, 32'h2402_0005);
        idle_cycle();
        new_data(0, 0, 32'h1000_0008, '0);
        round(0, 1, 32'h1122_3344);
        idle_cycle();
        new_data(1, 1, 32'h1000_0004, 32'hDEAD_BEEF);
        round(3, 0, '0);
        idle_cycle();

        // both requesters held continuously
        do_reset();
        order = "";
        for (int r = 0; r < 10; r++) begin
            if (!i_pend) new_fetch($urandom() & 32'h00FF_FFFC);
            if (!d_pend) new_data_rand();
            round($urandom_range(0, 1), $urandom_range(0, 1), $urandom());
        end
`ifdef MEM_ARB_ANTISTARVE_EN
        exp_order = "DDDDIDDDDI";
`else
        exp_order = "DDDDDDDDDD";
`endif
        chk_str("grant_order", order, exp_order);
        while (i_pend || d_pend) round(0, 0, $urandom());
        idle_cycle();

        // mem_rvalid in IDLE sets a sticky error; a fetch still completes
        bus.mem_rvalid = 1;
        @(negedge clk);
        check_rv("stray_rv");
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        exp_perr = 1;
        idle_cycle();
        new_fetch(32'h0040_0010);
        round(1, 2, 32'hCAFE_F00D);
        idle_cycle();

        // reset pulse while a read sits in RESP
        new_fetch(32'h0040_0020);
        bus.if_req = 1; bus.if_addr = i_addr;
        @(negedge clk);
        chk("rr_if_gnt", bus.if_gnt, 1);
        @(posedge clk); #1;
        bus.if_req = 0; bus.mem_gnt = 1;
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        @(negedge clk);
        chk("rr_busy_resp", busy, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rr_async_status", {busy, proto_err, bus.mem_req}, 0);
        chk("rr_async_rv", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt}, 0);
        chk("rr_async_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        bus.mem_rvalid = 1;
        bus.mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        check_rv("late_rv");
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        exp_perr = 1;
        idle_cycle();

        // mem_gnt without mem_req
        do_reset();
        bus.mem_gnt = 1;
        @(negedge clk);
        check_rv("stray_gnt");
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        exp_perr = 1;
        idle_cycle();

        // waiting requester drops its request before being granted
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h0040_0100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0100;
        @(negedge clk);
        chk("drop_d_gnt", bus.d_gnt, 1);
        @(posedge clk); #1;
        bus.d_req = 0; bus.if_req = 0;
        @(negedge clk);
        chk("drop_perr_before", proto_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_perr_after", proto_err, 1);
        chk("drop_busy_kept", {busy, bus.mem_req}, 2'b11);
        @(posedge clk); #1;

        // randomized traffic with random memory wait states
        do_reset();
        for (int r = 0; r < 30; r++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) new_fetch($urandom() & 32'h00FF_FFFC);
            if (!d_pend && $urandom_range(0, 1) == 1) new_data_rand();
            if (!i_pend && !d_pend) new_fetch($urandom() & 32'h00FF_FFFC);
            round($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
        end
        while (i_pend || d_pend) round(0, 0, $urandom());
        idle_cycle();
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage: LW/LB/LBU/SW/SB/SC).
- Accepts one transaction at a time, drives the memory request/grant/response handshake, and routes the response back to the owning requester.
- Data requests win by default, because the MEM stage is further down the pipeline. An optional anti-starvation guard protects fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held with the d_* inputs until d_gnt.
- d_we  in  1  1 = write.
- d_byte  in  1  byte access.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- d_rdata  out  DATA_W  load data; 0 on a write ack.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  memory write.
- mem_byte  out  1  memory byte access.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  a transaction is in flight (state != IDLE).
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: every output is 0, the state is IDLE, the owner is cleared and the starvation counter is 0. Reset asserted mid-transaction drops the transaction; no rvalid follows it.
- State IDLE:
  - If d_req or if_req is high, pick a winner and pulse its gnt for one cycle.
  - Register owner, we, byte, addr and wdata; go to REQ.
  - Fetch is always a read (mem_we=0, mem_byte=0).
- Winner selection:
  - d_req has priority over if_req.
  - With a single requester, that requester wins.
  - With no request, stay in IDLE with all pulses low.
- State REQ:
  - mem_req=1, and mem_* are driven from the registers only; they stay stable until mem_gnt.
  - On mem_gnt with a read, go to RESP.
  - On mem_gnt with a write, pulse d_rvalid the next cycle with d_rdata=0, then go to IDLE.
- State RESP:
  - mem_req=0; wait for mem_rvalid.
  - On mem_rvalid, capture mem_rdata and pulse the owner's rvalid/rdata the next cycle; go to IDLE.
  - The memory may hold off mem_rvalid any number of cycles; there is no timeout.
- Latency, zero-wait memory (mem_gnt in the first REQ cycle, mem_rvalid the following cycle):
  - gnt at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 2, requester rvalid at cycle 3.
  - A write ack arrives at cycle 2.
  - IDLE is re-entered on the rvalid/ack cycle, so the next gnt comes no earlier than that same cycle.
- rvalid and rdata are registered outputs. The non-owning requester's rvalid never pulses. rdata holds its last value between pulses.
- Requesters must not drop req before gnt.
- proto_err is set, and holds until reset, when any of these occur:
  - mem_rvalid while in IDLE or REQ;
  - mem_gnt while mem_req=0;
  - a requester's req falls while that requester is waiting in IDLE with no gnt yet issued.
- An event that sets proto_err otherwise leaves the FSM unchanged.
- gnt and rvalid from different transactions may fall in the same cycle; they are independent.

Optional Feature:
- Macro: MEM_ARB_ANTISTARVE_EN.
- Defined: a saturating counter counts IDLE arbitrations in which if_req=1 and data won. When the count reaches STARVE_MAX, the next arbitration with if_req=1 grants fetch even if d_req=1. The counter clears on any fetch grant.
- Undefined: strict data priority; no counter is instantiated.

Test Plan:
- if_req=1 with addr 0x0040_0000, zero-wait memory returns 0x2402_0005 -> if_gnt at cycle 0, mem_req at cycle 1 with mem_addr=0x0040_0000, if_rvalid at cycle 3 with if_rdata=0x2402_0005; d_rvalid stays 0.
- d_req write to 0x1000_0004 with d_wdata=0xDEAD_BEEF, d_byte=1, mem_gnt delayed 3 cycles -> mem_* stay stable for 4 cycles, then d_rvalid pulses with d_rdata=0; busy returns to 0.
- if_req and d_req both held high continuously, default build -> every grant goes to data; fetch is never granted; proto_err=0.
- Same stimulus with MEM_ARB_ANTISTARVE_EN and STARVE_MAX=4 -> grant order is D,D,D,D,IF,D,D,D,D,IF,...
- A read is in RESP and rst_n is pulsed low for 1 cycle -> all outputs go to 0 asynchronously; after reset, a late mem_rvalid sets proto_err=1 and produces no rvalid.
- mem_rvalid asserted while in IDLE -> proto_err=1 and stays 1; a following fetch still completes normally.
